// File: rtl/text_console_writer.sv
// text_console_writer: byte-stream sequencer for the character RAM write port.
// Tracks the cursor, decodes control codes and runs blanking sweeps.
module text_console_writer #(
  parameter int         COLS  = 80,
  parameter int         ROWS  = 60,
  parameter int         AW    = 13,
  parameter logic [7:0] BLANK = 8'h20
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic [7:0]    in_data,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          clear,
  output logic          busy,
  output logic [AW-1:0] waddr,
  output logic [7:0]    wdata,
  output logic          write_en,
  output logic [6:0]    cur_x,
  output logic [5:0]    cur_y
);

  localparam logic [1:0] FULLCLR = 2'd0;
  localparam logic [1:0] IDLE    = 2'd1;
  localparam logic [1:0] LINECLR = 2'd2;

  localparam logic [AW:0]   TOTAL    = (AW+1)'(COLS*ROWS);
  localparam logic [AW:0]   ONE      = (AW+1)'(1);
  localparam logic [6:0]    LAST_X   = 7'(COLS-1);
  localparam logic [5:0]    LAST_Y   = 6'(ROWS-1);
  localparam logic [6:0]    NCOLS    = 7'(COLS);
  localparam logic [AW-1:0] ROW_STEP = AW'(COLS);

  logic [1:0]    state;
  logic [AW:0]   sw_addr;
  logic [6:0]    sw_col;
  logic [AW-1:0] row_base;
  logic [AW-1:0] nxt_base;
  logic [AW-1:0] cur_addr;
  logic [AW-1:0] bs_addr;
  logic [AW-1:0] sw_waddr;
  logic [5:0]    nxt_y;
  logic          accept;
  logic          printable;

  assign in_ready  = (state == IDLE) && !clear;
  assign busy      = (state != IDLE);
  assign accept    = in_valid && in_ready;
  assign printable = (in_data >= 8'h20) && (in_data <= 8'h7E);

  // row_base tracks cur_y*COLS incrementally, so no multiplier is needed
  always_comb begin
    nxt_y    = (cur_y == LAST_Y) ? '0 : cur_y + 6'd1;
    nxt_base = (cur_y == LAST_Y) ? '0 : row_base + ROW_STEP;
    cur_addr = row_base + AW'(cur_x);
    bs_addr  = row_base + AW'(cur_x - 7'd1);
    sw_waddr = row_base + AW'(sw_col);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state    <= FULLCLR;
      sw_addr  <= '0;
      sw_col   <= '0;
      row_base <= '0;
      cur_x    <= '0;
      cur_y    <= '0;
      write_en <= 1'b0;
      waddr    <= '0;
      wdata    <= BLANK;
    end else begin
      write_en <= 1'b0;
      if (clear) begin
        state   <= FULLCLR;
        sw_addr <= '0;
      end else begin
        unique case (state)
          FULLCLR: begin
            if (sw_addr < TOTAL) begin
              write_en <= 1'b1;
              waddr    <= sw_addr[AW-1:0];
              wdata    <= BLANK;
              sw_addr  <= sw_addr + ONE;
            end else begin
              state    <= IDLE;
              cur_x    <= '0;
              cur_y    <= '0;
              row_base <= '0;
            end
          end
          LINECLR: begin
            if (sw_col < NCOLS) begin
              write_en <= 1'b1;
              waddr    <= sw_waddr;
              wdata    <= BLANK;
              sw_col   <= sw_col + 7'd1;
            end else begin
              state <= IDLE;
            end
          end
          IDLE: begin
            if (accept) begin
              unique case (1'b1)
                printable: begin
                  write_en <= 1'b1;
                  waddr    <= cur_addr;
                  wdata    <= in_data;
                  if (cur_x == LAST_X) begin
                    cur_x    <= '0;
                    cur_y    <= nxt_y;
                    row_base <= nxt_base;
                    sw_col   <= '0;
                    state    <= LINECLR;
                  end else begin
                    cur_x <= cur_x + 7'd1;
                  end
                end
                (in_data == 8'h0D): cur_x <= '0;
                // LF writes column 0 of the new row right away
                (in_data == 8'h0A): begin
                  cur_x    <= '0;
                  cur_y    <= nxt_y;
                  row_base <= nxt_base;
                  write_en <= 1'b1;
                  waddr    <= nxt_base;
                  wdata    <= BLANK;
                  sw_col   <= 7'd1;
                  state    <= LINECLR;
                end
                (in_data == 8'h08): begin
                  if (cur_x != '0) begin
                    cur_x    <= cur_x - 7'd1;
                    write_en <= 1'b1;
                    waddr    <= bs_addr;
                    wdata    <= BLANK;
                  end
                end
                (in_data == 8'h0C): begin
                  state   <= FULLCLR;
                  sw_addr <= '0;
                end
                default: ;
              endcase
            end
          end
          default: begin
            state   <= FULLCLR;
            sw_addr <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_text_console_writer.sv
// tb_text_console_writer: scoreboard bench for the character RAM writer.
// Expected writes are queued at stimulus time and popped per write_en.
module tb_text_console_writer;

  localparam int COLS  = 80;
  localparam int ROWS  = 60;
  localparam int AW    = 13;
  localparam int TOTAL = COLS * ROWS;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          clear = 1'b0;
  logic          busy;
  logic [AW-1:0] waddr;
  logic [7:0]    wdata;
  logic          write_en;
  logic [6:0]    cur_x;
  logic [5:0]    cur_y;

  int total = 0;
  int bad = 0;
  int mx = 0;
  int my = 0;
  logic [AW+7:0] sbq[$];
  logic [AW+7:0] mon_e;

  always #5 clk = ~clk;

  text_console_writer #(
    .COLS(COLS), .ROWS(ROWS), .AW(AW), .BLANK(8'h20)
  ) dut (
    .clk(clk),
    .rstn(rstn),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .clear(clear),
    .busy(busy),
    .waddr(waddr),
    .wdata(wdata),
    .write_en(write_en),
    .cur_x(cur_x),
    .cur_y(cur_y)
  );

  task automatic chk(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic push(input int a, input logic [7:0] d);
    sbq.push_back({AW'(a), d});
  endtask

  task automatic push_full();
    for (int a = 0; a < TOTAL; a++) push(a, 8'h20);
  endtask

  task automatic newline();
    mx = 0;
    my = (my == ROWS - 1) ? 0 : my + 1;
    for (int c = 0; c < COLS; c++) push(my * COLS + c, 8'h20);
  endtask

  task automatic model(input logic [7:0] b);
    if (b >= 8'h20 && b <= 8'h7E) begin
      push(my * COLS + mx, b);
      if (mx == COLS - 1) newline();
      else mx++;
    end else if (b == 8'h0D) begin
      mx = 0;
    end else if (b == 8'h0A) begin
      newline();
    end else if (b == 8'h08) begin
      if (mx > 0) begin
        mx--;
        push(my * COLS + mx, 8'h20);
      end
    end else if (b == 8'h0C) begin
      push_full();
      mx = 0;
      my = 0;
    end
  endtask

  always @(negedge clk) begin
    if (rstn && write_en) begin
      chk("sb_avail", int'(sbq.size() > 0), 1);
      if (sbq.size() > 0) begin
        mon_e = sbq.pop_front();
        chk("waddr", int'(waddr), int'(mon_e[AW+7:8]));
        chk("wdata", int'(wdata), int'(mon_e[7:0]));
      end
    end
  end

  task automatic wait_ready();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 10000);
    if (!in_ready) chk("ready_timeout", int'(in_ready), 1);
  endtask

  task automatic send(input logic [7:0] b);
    wait_ready();
    in_data = b;
    in_valid = 1'b1;
    model(b);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic chk_cursor(input string tag);
    chk({tag, "_x"}, int'(cur_x), mx);
    chk({tag, "_y"}, int'(cur_y), my);
  endtask

  task automatic settle(input string tag);
    wait_ready();
    repeat (3) @(negedge clk);
    chk({tag, "_drained"}, sbq.size(), 0);
  endtask

  task automatic full_sweep_chk(input string tag);
    int n = 0;
    for (int i = 0; i < TOTAL + 200; i++) begin
      @(negedge clk);
      if (write_en) n++;
      else if (n > 0) break;
    end
    chk({tag, "_len"}, n, TOTAL);
    chk({tag, "_rdy"}, int'(in_ready), 1);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    @(negedge clk);
    chk("rst_we", int'(write_en), 0);
    chk("rst_waddr", int'(waddr), 0);
    chk("rst_wdata", int'(wdata), 32);
    chk("rst_rdy", int'(in_ready), 0);
    chk("rst_busy", int'(busy), 1);
    chk_cursor("rst");
    push_full();
    @(negedge clk);
    rstn = 1'b1;
    full_sweep_chk("por");
    chk_cursor("por");

    // back-to-back "AB"
    wait_ready();
    in_data = 8'h41;
    in_valid = 1'b1;
    model(8'h41);
    @(posedge clk);
    #1 in_data = 8'h42;
    model(8'h42);
    @(negedge clk);
    chk("b2b_rdy", int'(in_ready), 1);
    chk("b2b_wr0", int'(write_en), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("b2b_wr1", int'(write_en), 1);
    chk_cursor("b2b");

    send(8'h0D);
    send(8'h08);
    send(8'h01);
    send(8'h7F);
    settle("bs0");
    chk_cursor("bs0");

    send(8'h0A);
    send(8'h0A);
    for (int i = 0; i < 7; i++) send(8'h61 + 8'(i));
    send(8'h08);
    settle("bs7");
    chk_cursor("bs7");

    send(8'h0D);
    send(8'h0A);
    for (int i = 0; i < 5; i++) send(8'h30 + 8'(i));
    begin
      int n = 0;
      send(8'h0A);
      for (int i = 0; i < 300; i++) begin
        @(negedge clk);
        if (in_ready) break;
        n++;
      end
      chk("lf_rdy_low", n, COLS);
    end
    settle("lf");
    chk_cursor("lf");

    for (int i = 0; i < 55; i++) send(8'h0A);
    for (int i = 0; i < COLS - 1; i++) send(8'h61 + 8'(i % 26));
    send(8'h5A);
    settle("wrap");
    chk_cursor("wrap");

    send(8'h0C);
    full_sweep_chk("ff");
    chk_cursor("ff");

    // clear together with a byte during a line sweep
    send(8'h0A);
    repeat (10) @(negedge clk);
    clear = 1'b1;
    in_valid = 1'b1;
    in_data = 8'h41;
    chk("clr_rdy", int'(in_ready), 0);
    chk("clr_busy", int'(busy), 1);
    @(posedge clk);
    #1 clear = 1'b0;
    in_valid = 1'b0;
    sbq.delete();
    push_full();
    mx = 0;
    my = 0;
    full_sweep_chk("clr");
    chk_cursor("clr");

    // reset in the middle of a full sweep
    send(8'h0C);
    repeat (100) @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("mid_rst_we", int'(write_en), 0);
    chk("mid_rst_waddr", int'(waddr), 0);
    chk("mid_rst_rdy", int'(in_ready), 0);
    chk("mid_rst_busy", int'(busy), 1);
    sbq.delete();
    push_full();
    @(negedge clk);
    rstn = 1'b1;
    full_sweep_chk("rst2");
    chk_cursor("rst2");
    settle("end");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
